uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame (legal 5..9).
REQ-002 Parameter PRESCALE_WIDTH, default 6, width of the PRESCALE port.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- CLK  in  1  oversampling clock; all logic on its rising edge.
- RST  in  1  asynchronous active-low reset.
REQ-004 Inputs:
- RX_IN  in  1  serial line; idle high; no internal synchroniser.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits, 0 = one stop bit.
- PRESCALE  in  PRESCALE_WIDTH  CLK cycles per bit (legal 4..32).
REQ-005 Outputs:
- P_DATA  out  DATA_WIDTH  received payload, LSB first on the line.
- DATA_VLD  out  1  one-cycle pulse; frame good.
- PAR_ERR  out  1  one-cycle pulse; parity mismatch.
- STP_ERR  out  1  one-cycle pulse; stop bit sampled low.

Function
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the only exit from IDLE is to START.
REQ-007 IDLE -> START SHALL occur in the first cycle t0 in which RX_IN is sampled 0; the edge counter SHALL be 0 at t0.
REQ-008 PAR_EN, PAR_TYP, STOP2 and PRESCALE SHALL be latched at t0; changes mid-frame SHALL NOT affect the frame.
REQ-009 Latched PRESCALE values below 4 SHALL be treated as 4.
REQ-010 The edge counter SHALL count 0..P-1 per bit, where P is the latched prescale, then wrap; a bit counter SHALL track the data bits.
REQ-011 Each bit SHALL be the majority of three samples at edge counts P/2-1, P/2 and P/2+1 (integer division).
REQ-012 If the start bit resolves to 1 (glitch), the FSM SHALL return to IDLE at the end of the start-bit period with no output pulse.
REQ-013 The DATA state SHALL shift DATA_WIDTH bits into a shadow register, LSB first.
REQ-014 In the PARITY state, the expected parity bit SHALL be the XOR of the data bits (even) or its inverse (odd); a mismatch SHALL set an internal error flag.
REQ-015 The STOP state SHALL last one bit period, or two when STOP2 is set; any stop sample resolving to 0 SHALL set the stop-error flag.
REQ-016 Let N = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2. At cycle t0 + N*P the block SHALL pulse exactly one of:
- DATA_VLD, when there is no error; P_DATA is loaded in the same cycle.
- PAR_ERR and/or STP_ERR, when an error was flagged; no DATA_VLD.
REQ-017 P_DATA SHALL hold its value until the next good frame; errored frames SHALL NOT update it.
REQ-018 At cycle t0 + N*P the FSM SHALL be in IDLE, and a 0 on RX_IN in that cycle SHALL start a new frame (back-to-back frames, no gap).
REQ-019 An X-free RX_IN held low indefinitely SHALL yield repeated STP_ERR pulses and never lock up.

Reset
REQ-020 Asserting RST SHALL immediately force:
- FSM to IDLE;
- all counters and the shadow register to 0;
- P_DATA to 0;
- DATA_VLD, PAR_ERR and STP_ERR to 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; the first falling edge after deassertion starts a fresh frame.

Structure
REQ-022 Package uart_pkg SHALL hold:
- the FSM state encoding;
- the PAR_EVEN and PAR_ODD constants;
- the minimum prescale constant (4).
REQ-023 Sub-module uart_rx_sampler SHALL contain the edge counter and the 3-sample majority logic, and provide a bit-done strobe and the sampled bit.

Verification
REQ-024 P=8, 8E1, send 0xA5 with correct parity -> P_DATA=0xA5 and a DATA_VLD pulse at t0+88; no error pulses.
REQ-025 P=16, 8O1, send 0x3C with the parity bit inverted -> PAR_ERR pulse at t0+176; P_DATA unchanged.
REQ-026 P=32, 8N2, second stop bit driven 0 -> STP_ERR pulse at t0+352; no DATA_VLD.
REQ-027 P=16, RX_IN low for only 3 cycles -> no pulses; FSM back in IDLE by t0+16.
REQ-028 Two back-to-back frames 0x11 and 0xEE at P=8, 8N1 -> DATA_VLD at t0+80 and t0+160, with P_DATA matching each frame.
REQ-029 RST asserted mid-DATA, then a full 0x5A frame -> outputs 0 during reset, then DATA_VLD with P_DATA=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, parity selectors and prescale floor for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority vote around mid-bit
module uart_rx_sampler #(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          rx,
  input  logic [PW-1:0] prescale,
  output logic          bit_done,
  output logic          bit_val
);
  logic [PW-1:0] cnt, half;
  logic [2:0] smp;
  logic late;
  assign half = prescale >> 1;
  assign bit_done = run && cnt == prescale - PW'(1);
  // at the smallest prescale the third sample lands on the last edge, so take it live
  assign late = (cnt == half + PW'(1)) ? rx : smp[2];
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & late) | (smp[1] & late);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      smp <= '0;
    end else begin
      cnt <= (bit_done || !run) ? '0 : cnt + PW'(1);
      if (run && cnt == half - PW'(1)) smp[0] <= rx;
      if (run && cnt == half) smp[1] <= rx;
      if (run && cnt == half + PW'(1)) smp[2] <= rx;
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with per-frame latched parity, stop-bit and prescale configuration
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VLD,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);
  localparam logic [PRESCALE_WIDTH-1:0] PMIN = PRESCALE_WIDTH'(MIN_PRESCALE);
  state_t state;
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic [DATA_WIDTH-1:0] shadow;
  logic [3:0] bit_cnt;
  logic par_en_l, par_typ_l, stop2_l, par_err_f, stp_err_f;
  logic run, bit_done, bit_val, stop_bad, par_bad;
  assign run = state != IDLE || !RX_IN;
  assign stop_bad = stp_err_f || !bit_val;
  assign par_bad = bit_val != (^shadow ^ (par_typ_l == PAR_ODD));
  uart_rx_sampler #(.PW(PRESCALE_WIDTH)) u_sampler (
    .clk(CLK), .rst_n(RST), .run(run), .rx(RX_IN), .prescale(p_lat),
    .bit_done(bit_done), .bit_val(bit_val)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      p_lat <= PMIN;
      shadow <= '0;
      bit_cnt <= '0;
      {par_en_l, par_typ_l, stop2_l, par_err_f, stp_err_f} <= '0;
      P_DATA <= '0;
      {DATA_VLD, PAR_ERR, STP_ERR} <= '0;
    end else begin
      {DATA_VLD, PAR_ERR, STP_ERR} <= '0;
      case (state)
        IDLE: if (!RX_IN) begin
          state <= START;
          p_lat <= (PRESCALE < PMIN) ? PMIN : PRESCALE;
          {par_en_l, par_typ_l, stop2_l} <= {PAR_EN, PAR_TYP, STOP2};
          {par_err_f, stp_err_f} <= '0;
          bit_cnt <= '0;
        end
        START: if (bit_done) state <= bit_val ? IDLE : DATA;
        DATA: if (bit_done) begin
          shadow <= {bit_val, shadow[DATA_WIDTH-1:1]};
          bit_cnt <= (bit_cnt == 4'(DATA_WIDTH - 1)) ? 4'd0 : bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_WIDTH - 1)) state <= par_en_l ? PARITY : STOP;
        end
        PARITY: if (bit_done) begin
          par_err_f <= par_bad;
          state <= STOP;
        end
        STOP: if (bit_done) begin
          if (stop2_l && bit_cnt == 4'd0) begin
            bit_cnt <= 4'd1;
            stp_err_f <= stop_bad;
          end else begin
            state <= IDLE;
            DATA_VLD <= !par_err_f && !stop_bad;
            PAR_ERR <= par_err_f;
            STP_ERR <= stop_bad;
            if (!par_err_f && !stop_bad) P_DATA <= shadow;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed and random frames checked every cycle against a line-sampling reference model
module tb_uart_rx_cfg;
  localparam int DW = 8;
  localparam int PW = 6;
  localparam int MAXC = 40000;
  logic CLK = 0, RST = 0, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0, STOP2 = 0;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic [DW-1:0] P_DATA;
  logic DATA_VLD, PAR_ERR, STP_ERR;
  int checks = 0, failures = 0, cyc = -1;
  bit line [MAXC];
  bit vld_at [MAXC], perr_at [MAXC], serr_at [MAXC];
  logic [DW-1:0] pd_at [MAXC];

  uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VLD(DATA_VLD),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // majority of the three line samples taken around the middle of bit b of a frame starting at t0
  function automatic bit maj(input int t0, input int b, input int p);
    int a;
    a = t0 + b * p + p / 2 - 1;
    return (int'(line[a]) + int'(line[a + 1]) + int'(line[a + 2])) >= 2;
  endfunction

  initial begin : model
    bit busy, pen, ptyp, s2, rst_s, pen_s, ptyp_s, s2_s, ev, ep, es, ok_p, ok_s;
    int t0, p, n, pre_s;
    logic [DW-1:0] exp_pd, d;
    busy = 0; exp_pd = '0; t0 = 0; p = 4; n = 0;
    {pen, ptyp, s2} = '0;
    forever begin
      @(posedge CLK);
      cyc++;
      if (cyc >= MAXC - 2) begin
        $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC - 2);
        $fatal(1, "cycle budget exhausted");
      end
      line[cyc] = RX_IN;
      rst_s = RST;
      {pen_s, ptyp_s, s2_s} = {PAR_EN, PAR_TYP, STOP2};
      pre_s = int'(PRESCALE);
      #1;
      ev = 0; ep = 0; es = 0;
      if (!rst_s) begin
        busy = 0;
        exp_pd = '0;
      end else if (!busy) begin
        if (!line[cyc]) begin
          busy = 1; t0 = cyc;
          pen = pen_s; ptyp = ptyp_s; s2 = s2_s;
          p = pre_s < 4 ? 4 : pre_s;
          n = 2 + DW + int'(pen) + int'(s2);
        end
      end else if (cyc - t0 == p - 1 && maj(t0, 0, p)) begin
        busy = 0;
      end else if (cyc - t0 == n * p - 1) begin
        for (int i = 0; i < DW; i++) d[i] = maj(t0, 1 + i, p);
        ok_p = !pen || (maj(t0, 1 + DW, p) == ((^d) ^ ptyp));
        ok_s = 1;
        for (int s = 0; s < 1 + int'(s2); s++)
          if (!maj(t0, 1 + DW + int'(pen) + s, p)) ok_s = 0;
        ep = !ok_p; es = !ok_s; ev = ok_p && ok_s;
        if (ev) exp_pd = d;
        busy = 0;
      end
      vld_at[cyc + 1] = DATA_VLD;
      perr_at[cyc + 1] = PAR_ERR;
      serr_at[cyc + 1] = STP_ERR;
      pd_at[cyc + 1] = P_DATA;
      chk("data_vld", DATA_VLD, ev);
      chk("par_err", PAR_ERR, ep);
      chk("stp_err", STP_ERR, es);
      chk("p_data", P_DATA, exp_pd);
    end
  end

  task automatic idle(input int n);
    RX_IN = 1;
    repeat (n) @(negedge CLK);
  endtask

  // called on a negedge; the start bit is sampled at the following posedge t0
  task automatic send(input logic [DW-1:0] d, input bit pen, input bit ptyp, input bit s2,
                      input int pre, input bit bad_par, input bit bad_stop, input bit scramble,
                      output int t0);
    bit fb [16];
    int nb, p;
    p = pre < 4 ? 4 : pre;
    fb[0] = 0;
    for (int i = 0; i < DW; i++) fb[1 + i] = d[i];
    nb = 1 + DW;
    if (pen) begin fb[nb] = (^d) ^ ptyp ^ bad_par; nb++; end
    fb[nb] = 1; nb++;
    if (s2) begin fb[nb] = 1; nb++; end
    if (bad_stop) fb[nb - 1] = 0;
    PAR_EN = pen; PAR_TYP = ptyp; STOP2 = s2; PRESCALE = PW'(pre);
    t0 = cyc + 1;
    for (int b = 0; b < nb; b++) begin
      RX_IN = fb[b];
      if (scramble && b == 1) begin
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
        PRESCALE = PW'($urandom_range(0, 32));
      end
      repeat (p) @(negedge CLK);
    end
  endtask

  initial begin : stim
    int t0, t1, pre;
    bit quiet;
    repeat (3) @(negedge CLK);
    chk("reset_p_data", P_DATA, 0);
    chk("reset_vld", DATA_VLD, 0);
    RST = 1;
    idle(4);
    send(8'hA5, 1, 0, 0, 8, 0, 0, 0, t0);
    idle(4);
    chk("8e1_vld", vld_at[t0 + 88], 1);
    chk("8e1_vld_early", vld_at[t0 + 87], 0);
    chk("8e1_data", pd_at[t0 + 88], 8'hA5);
    chk("8e1_errs", {perr_at[t0 + 88], serr_at[t0 + 88]}, 0);
    send(8'h3C, 1, 1, 0, 16, 1, 0, 0, t0);
    idle(4);
    chk("8o1_par_err", perr_at[t0 + 176], 1);
    chk("8o1_no_vld", vld_at[t0 + 176], 0);
    chk("8o1_data_held", pd_at[t0 + 176], 8'hA5);
    send(8'h81, 0, 0, 1, 32, 0, 1, 0, t0);
    idle(4);
    chk("8n2_stp_err", serr_at[t0 + 352], 1);
    chk("8n2_no_vld", vld_at[t0 + 352], 0);
    PRESCALE = 16; PAR_EN = 0; STOP2 = 0; RX_IN = 0;
    t0 = cyc + 1;
    repeat (3) @(negedge CLK);
    RX_IN = 1;
    repeat (13) @(negedge CLK);
    send(8'h77, 0, 0, 0, 16, 0, 0, 0, t1);
    idle(3);
    quiet = 1;
    for (int c = t0; c <= t0 + 16; c++) if (vld_at[c] || perr_at[c] || serr_at[c]) quiet = 0;
    chk("glitch_quiet", quiet, 1);
    chk("glitch_restart_vld", vld_at[t0 + 16 + 160], 1);
    chk("glitch_restart_data", pd_at[t0 + 16 + 160], 8'h77);
    send(8'h11, 0, 0, 0, 8, 0, 0, 0, t0);
    send(8'hEE, 0, 0, 0, 8, 0, 0, 0, t1);
    idle(4);
    chk("b2b_vld0", vld_at[t0 + 80], 1);
    chk("b2b_data0", pd_at[t0 + 80], 8'h11);
    chk("b2b_vld1", vld_at[t0 + 160], 1);
    chk("b2b_data1", pd_at[t0 + 160], 8'hEE);
    send(8'hC3, 0, 0, 0, 2, 0, 0, 0, t0);
    idle(4);
    chk("clamp_vld", vld_at[t0 + 40], 1);
    chk("clamp_data", pd_at[t0 + 40], 8'hC3);
    PRESCALE = 8; RX_IN = 0;
    repeat (8) @(negedge CLK);
    RX_IN = 1;
    repeat (20) @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);
    chk("midrst_p_data", P_DATA, 0);
    chk("midrst_outs", {DATA_VLD, PAR_ERR, STP_ERR}, 0);
    repeat (3) @(negedge CLK);
    RST = 1;
    idle(3);
    send(8'h5A, 0, 0, 0, 8, 0, 0, 0, t0);
    idle(4);
    chk("post_rst_vld", vld_at[t0 + 80], 1);
    chk("post_rst_data", pd_at[t0 + 80], 8'h5A);
    PRESCALE = 8; PAR_EN = 0; STOP2 = 0; RX_IN = 0;
    t0 = cyc + 1;
    repeat (3 * 80 + 2) @(negedge CLK);
    idle(90);
    chk("stuck_low_serr0", serr_at[t0 + 80], 1);
    chk("stuck_low_serr1", serr_at[t0 + 160], 1);
    chk("stuck_low_serr2", serr_at[t0 + 240], 1);
    chk("stuck_low_no_vld", vld_at[t0 + 80], 0);
    for (int f = 0; f < 60; f++) begin
      pre = $urandom_range(0, 32);
      send(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), pre,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1, t0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
    end
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
